disp_digit_conv: RTL and testbench
==================================

DISP_DIGIT_CONV -- requirements
Module: disp_digit_conv

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bit width of the binary input value.
REQ-002 SHALL have parameter DIGITS, default 3: number of 4-bit display digits produced; legal range 1..8.
REQ-003 SHALL have port clk, input, 1: sole clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1: request a conversion of value; sampled only in IDLE.
REQ-006 SHALL have port value, input, WIDTH: binary number to display.
REQ-007 SHALL have port dec_mode, input, 1: 1 = decimal (BCD) digits, 0 = hex digits; sampled with start.
REQ-008 SHALL have port busy, output, 1: high while a conversion is in progress (state not IDLE).
REQ-009 SHALL have port done, output, 1: single-cycle pulse when digits/overflow/blank update.
REQ-010 SHALL have port digits, output, 4*DIGITS: digit nibbles; bits [3:0] are the least significant digit.
REQ-011 SHALL have port overflow, output, 1: last result saturated because value did not fit in DIGITS digits.
REQ-012 SHALL have port blank, output, DIGITS: per-digit blanking mask for leading zeros (see Configuration).

Function
REQ-013 SHALL implement states IDLE, LOAD, SHIFT, DONE; IDLE->LOAD on start; LOAD->SHIFT (dec) or LOAD->DONE (hex); SHIFT->DONE after exactly WIDTH shift cycles; DONE->IDLE unconditionally.
REQ-014 SHALL latch value and dec_mode in the start cycle; later changes to value/dec_mode SHALL not affect the running conversion.
REQ-015 SHALL ignore start while busy is high; no queueing.
REQ-016 Decimal mode SHALL use iterative shift-add-3 (double dabble): one bit per SHIFT cycle, each BCD digit >= 5 incremented by 3 before the shift.
REQ-017 Decimal latency SHALL be WIDTH+2 cycles from start sampled to done high; hex latency SHALL be 2 cycles.
REQ-018 Hex mode SHALL pass value through as nibbles, zero-extended to 4*DIGITS bits.
REQ-019 If value >= 10^DIGITS (dec) or >= 16^DIGITS (hex), digits SHALL saturate to all 9 (dec) or all F (hex) and overflow SHALL be 1; otherwise overflow SHALL be 0.
REQ-020 digits, overflow and blank SHALL update only in the DONE cycle and hold until the next DONE.
REQ-021 start asserted in the DONE cycle SHALL be ignored; start in the following IDLE cycle SHALL be accepted (back-to-back throughput WIDTH+3 cycles dec, 3 cycles hex).
REQ-022 value = 0 SHALL produce all-zero digits, overflow 0.

Reset
REQ-023 rst_n low SHALL immediately force state IDLE, busy 0, done 0, digits 0, overflow 0, blank 0, including mid-conversion; the aborted conversion SHALL produce no done.
REQ-024 First start SHALL be accepted in the first clock edge after rst_n deasserts.

Configuration
REQ-025 Macro DISP_LEADING_BLANK_EN defined: in DONE, blank[i] SHALL be 1 for every digit i above the most significant non-zero digit; blank[0] SHALL always be 0; overflow results SHALL have blank all 0.
REQ-026 Macro DISP_LEADING_BLANK_EN undefined: blank SHALL be constant 0 and no blanking logic synthesised.

Structure
REQ-027 Package disp_pkg SHALL hold the state enum type, DIG_W = 4, BCD_ADJ_THRESH = 5, BCD_ADJ_ADD = 3 and a constant function for 10^N/16^N limits.
REQ-028 One sub-module bcd_adjust SHALL implement the per-digit add-3 cell, instantiated DIGITS times via generate.
REQ-029 Saturation limits SHALL be compile-time constants sized to WIDTH+1 bits minimum; no runtime multiply/divide.

Verification
REQ-030 WIDTH=8, DIGITS=3, dec: value=8'd255, start -> done at cycle 10, digits=12'h255, overflow 0.
REQ-031 WIDTH=8, DIGITS=2, dec: value=8'd123 -> digits=8'h99, overflow 1; hex: value=8'hA7 -> digits=8'hA7, done at cycle 2, overflow 0.
REQ-032 Dec conversion running, pulse start with value=8'd9 at cycle 4 -> ignored; result matches original value, single done.
REQ-033 rst_n low at cycle 5 of a dec conversion -> all outputs 0 immediately, no done; new start after release converts 8'd42 -> 12'h042.
REQ-034 DISP_LEADING_BLANK_EN defined, DIGITS=3, dec 8'd7 -> digits=12'h007, blank=3'b110; 8'd0 -> blank=3'b110; undefined -> blank=3'b000.
REQ-035 Exhaustive sweep value 0..255 both modes, back-to-back starts -> every result matches reference model, throughput 11/3 cycles.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared types and constants for the display digit converter.
// Holds the FSM state type, BCD cell constants and the saturation-limit helper.
package disp_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StShift,
        StDone
    } conv_state_e;

    localparam int unsigned DIG_W          = 4;
    localparam int unsigned BCD_ADJ_THRESH = 5;
    localparam int unsigned BCD_ADJ_ADD    = 3;

    // base**n, evaluated only at elaboration to build the saturation limits
    function automatic logic [63:0] pow_limit(input int unsigned base, input int unsigned n);
        logic [63:0] acc;
        acc = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            acc = acc * 64'(base);
        end
        return acc;
    endfunction

endpackage

// File: rtl/bcd_adjust.sv
// Double-dabble cell: adds 3 to a BCD digit of 5 or more ahead of the left shift.
module bcd_adjust
    import disp_pkg::*;
(
    input  logic [DIG_W-1:0] din,
    output logic [DIG_W-1:0] dout
);

    assign dout = (din >= DIG_W'(BCD_ADJ_THRESH)) ? din + DIG_W'(BCD_ADJ_ADD) : din;

endmodule

// File: rtl/disp_digit_conv.sv
// Binary to display-digit converter: iterative BCD (double dabble) or hex nibbles, saturating.
// Optional leading-zero blanking mask enabled by defining DISP_LEADING_BLANK_EN.
module disp_digit_conv
    import disp_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [WIDTH-1:0]        value,
    input  logic                    dec_mode,
    output logic                    busy,
    output logic                    done,
    output logic [DIG_W*DIGITS-1:0] digits,
    output logic                    overflow,
    output logic [DIGITS-1:0]       blank
);

    localparam int unsigned DW   = DIG_W * DIGITS;
    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam int unsigned LimW = (WIDTH + 1 > 34) ? WIDTH + 1 : 34;

    localparam logic [LimW-1:0] DecLimit = LimW'(pow_limit(10, DIGITS));
    localparam logic [LimW-1:0] HexLimit = LimW'(pow_limit(16, DIGITS));

    conv_state_e     state_q, state_d;
    logic [WIDTH-1:0] val_q, val_d;
    logic            dec_q, dec_d;
    logic            sat_q, sat_d;
    logic [DW-1:0]   bcd_q, bcd_d, bcd_adj;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]  sh;
    logic [DW-1:0]   res;
    logic [DW-1:0]   digits_q;
    logic            ovf_q;
    logic            done_q;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_adjust u_bcd_adjust (
            .din  (bcd_q[DIG_W*g +: DIG_W]),
            .dout (bcd_adj[DIG_W*g +: DIG_W])
        );
    end

    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        dec_d   = dec_q;
        sat_d   = sat_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        // {bcd, val} shifts left as one register; the bit falling off the top digit
        // rotates into val's vacated LSB (only reachable when saturating anyway)
        sh      = {val_q, bcd_adj[DW-1]};

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoad;
                    val_d   = value;
                    dec_d   = dec_mode;
                    sat_d   = dec_mode ? (LimW'(value) >= DecLimit) : (LimW'(value) >= HexLimit);
                end
            end
            StLoad: begin
                bcd_d   = '0;
                cnt_d   = '0;
                state_d = dec_q ? StShift : StDone;
            end
            StShift: begin
                bcd_d = {bcd_adj[DW-2:0], sh[WIDTH]};
                val_d = sh[WIDTH-1:0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        res = dec_q ? bcd_d : DW'(val_q);
        if (sat_q) begin
            res = dec_q ? {DIGITS{4'h9}} : {DIGITS{4'hF}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            val_q    <= '0;
            dec_q    <= 1'b0;
            sat_q    <= 1'b0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            digits_q <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            dec_q   <= dec_d;
            sat_q   <= sat_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            done_q  <= (state_d == StDone);
            if (state_d == StDone) begin
                digits_q <= res;
                ovf_q    <= sat_q;
            end
        end
    end

`ifdef DISP_LEADING_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_d;
    logic              nz_seen;

    always_comb begin
        blank_d = '0;
        nz_seen = 1'b0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            nz_seen    = nz_seen | (res[DIG_W*i +: DIG_W] != '0);
            blank_d[i] = !nz_seen && !sat_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_q <= '0;
        end else if (state_d == StDone) begin
            blank_q <= blank_d;
        end
    end

    assign blank = blank_q;
`else
    assign blank = '0;
`endif

    assign busy     = (state_q != StIdle);
    assign done     = done_q;
    assign digits   = digits_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_disp_digit_conv.sv
// Self-checking bench for disp_digit_conv: 3-digit and 2-digit instances driven in parallel.
module tb_disp_digit_conv;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        dec_mode = 1'b0;
    logic [7:0]  value = 8'd0;

    logic        busy3, done3, ovf3;
    logic [11:0] dig3;
    logic [2:0]  blk3;
    logic        busy2, done2, ovf2;
    logic [7:0]  dig2;
    logic [1:0]  blk2;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_dig3 = '0;

    always #5 clk = ~clk;

    disp_digit_conv #(.WIDTH(8), .DIGITS(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .value(value), .dec_mode(dec_mode),
        .busy(busy3), .done(done3), .digits(dig3), .overflow(ovf3), .blank(blk3)
    );

    disp_digit_conv #(.WIDTH(8), .DIGITS(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .value(value), .dec_mode(dec_mode),
        .busy(busy2), .done(done2), .digits(dig2), .overflow(ovf2), .blank(blk2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: positional digits by division, saturation by comparing against base**n.
    function automatic void model(input int v, input bit dec, input int n,
                                  output logic [31:0] dig, output logic ovf,
                                  output logic [7:0] blk);
        int base;
        int lim;
        int r;
        int msd;
        base = dec ? 10 : 16;
        lim  = 1;
        msd  = 0;
        dig  = '0;
        blk  = '0;
        ovf  = 1'b0;
        for (int i = 0; i < n; i++) lim = lim * base;
        if (v >= lim) begin
            ovf = 1'b1;
            for (int i = 0; i < n; i++) dig[4*i +: 4] = 4'(base - 1);
        end else begin
            r = v;
            for (int i = 0; i < n; i++) begin
                dig[4*i +: 4] = 4'(r % base);
                if (r % base != 0) msd = i;
                r = r / base;
            end
            for (int i = 1; i < n; i++) blk[i] = (i > msd);
        end
`ifndef DISP_LEADING_BLANK_EN
        blk = '0;
`endif
    endfunction

    task automatic check_results(input int v, input bit dec);
        logic [31:0] d;
        logic        o;
        logic [7:0]  b;
        model(v, dec, 3, d, o, b);
        check("digits3", 32'(dig3), d);
        check("ovf3", 32'(ovf3), 32'(o));
        check("blank3", 32'(blk3), 32'(b[2:0]));
        last_dig3 = d;
        model(v, dec, 2, d, o, b);
        check("digits2", 32'(dig2), d);
        check("ovf2", 32'(ovf2), 32'(o));
        check("blank2", 32'(blk2), 32'(b[1:0]));
    endtask

    // Called at a negedge; ends at the negedge of the DONE cycle.
    task automatic run_conv(input int v, input bit dec, input bit from_done, input bit poke);
        int lat;
        bit got;
        start    = 1'b1;
        value    = 8'(v);
        dec_mode = dec;
        if (from_done) begin
            @(posedge clk);
            @(negedge clk);
            check("idle_after_done", 32'(busy3), 32'd0);
        end
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        value    = 8'($urandom);
        dec_mode = 1'($urandom);
        lat = 0;
        got = 1'b0;
        for (int c = 1; c <= 40 && !got; c++) begin
            if (done3) begin
                got = 1'b1;
                lat = c;
            end else begin
                if (poke && c == 4) begin
                    start = 1'b1;
                    value = 8'd9;
                end else if (poke && c == 5) begin
                    start = 1'b0;
                end
                @(negedge clk);
            end
        end
        check("latency", 32'(lat), dec ? 32'd10 : 32'd2);
        check("done2", 32'(done2), 32'd1);
        check("busy_in_done", 32'(busy3), 32'd1);
        check_results(v, dec);
    endtask

    task automatic pulse_end();
        @(negedge clk);
        check("done_pulse", 32'(done3), 32'd0);
        check("busy_idle", 32'(busy3), 32'd0);
        check("hold", 32'(dig3), last_dig3);
    endtask

    initial begin
        // reset state
        #12;
        check("rst_busy", 32'(busy3), 32'd0);
        check("rst_done", 32'(done3), 32'd0);
        check("rst_digits", 32'(dig3), 32'd0);
        check("rst_ovf", 32'(ovf3), 32'd0);
        check("rst_blank", 32'(blk3), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_conv(255, 1'b1, 1'b0, 1'b0);
        pulse_end();
        run_conv(123, 1'b1, 1'b0, 1'b0);
        run_conv(8'hA7, 1'b0, 1'b1, 1'b0);
        pulse_end();
        // start pulsed mid-conversion must be ignored
        run_conv(200, 1'b1, 1'b0, 1'b1);
        pulse_end();
        repeat (3) begin
            @(negedge clk);
            check("no_extra_done", 32'(done3), 32'd0);
        end

        // reset in the middle of a decimal conversion
        start    = 1'b1;
        value    = 8'd200;
        dec_mode = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy3), 32'd0);
        check("abort_done", 32'(done3), 32'd0);
        check("abort_digits", 32'(dig3), 32'd0);
        check("abort_ovf", 32'(ovf3), 32'd0);
        check("abort_blank", 32'(blk3), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("abort_no_done", 32'(done3), 32'd0);
        end
        rst_n = 1'b1;
        run_conv(42, 1'b1, 1'b0, 1'b0);
        run_conv(7, 1'b1, 1'b1, 1'b0);
        run_conv(0, 1'b1, 1'b1, 1'b0);
        run_conv(0, 1'b0, 1'b1, 1'b0);

        // exhaustive back-to-back sweep, both modes
        for (int v = 0; v < 256; v++) begin
            run_conv(v, 1'b1, 1'b1, 1'b0);
            run_conv(v, 1'b0, 1'b1, 1'b0);
        end

        // randomized back-to-back traffic
        for (int k = 0; k < 200; k++) begin
            run_conv(int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
        end
        pulse_end();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
